// File: rtl/parking_slot_manager_if.sv
`default_nettype none
// ============================================================================
// Module      : parking_slot_manager_if
// Description : Request/response bundle between the gate sensors and the
//               parking slot allocator.
//               Gate side (master) drives: entry, exit, exit_idx
//               Allocator side (slave) drives: free_map, grant_valid,
//               grant_onehot, grant_idx, deny, exit_err, free_count,
//               full, empty, entries_total
// Revision    : 1.0 - initial release
// ============================================================================
interface parking_slot_manager_if #(
  parameter int NUM_SLOTS = 8,
  parameter int IDX_W     = 3,
  parameter int CNT_W     = 16
);
  logic                 entry;
  logic                 exit;
  logic [IDX_W-1:0]     exit_idx;
  logic [NUM_SLOTS-1:0] free_map;
  logic                 grant_valid;
  logic [NUM_SLOTS-1:0] grant_onehot;
  logic [IDX_W-1:0]     grant_idx;
  logic                 deny;
  logic                 exit_err;
  logic [IDX_W:0]       free_count;
  logic                 full;
  logic                 empty;
  logic [CNT_W-1:0]     entries_total;

  modport master (
    output entry, exit, exit_idx,
    input  free_map, grant_valid, grant_onehot, grant_idx, deny, exit_err,
           free_count, full, empty, entries_total
  );

  modport slave (
    input  entry, exit, exit_idx,
    output free_map, grant_valid, grant_onehot, grant_idx, deny, exit_err,
           free_count, full, empty, entries_total
  );
endinterface
`default_nettype wire

// File: rtl/parking_slot_manager.sv
`default_nettype none
// ============================================================================
// Module      : parking_slot_manager
// Description : Registered slot allocator. Keeps an occupancy map of
//               NUM_SLOTS spaces, grants the lowest-index free slot on each
//               entry request, frees slots on exit by index, and maintains a
//               free-slot counter and a wrapping lifetime entry counter.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous active-high reset
//               psm   - slave side of parking_slot_manager_if
//                       (requests in; map, pulses and counters out,
//                       all registered)
// Revision    : 1.0 - initial release
// ============================================================================
module parking_slot_manager #(
  parameter int NUM_SLOTS = 8,
  parameter int IDX_W     = 3,
  parameter int CNT_W     = 16
) (
  input  wire logic               clk,
  input  wire logic               reset,
  parking_slot_manager_if.slave   psm
);

  localparam logic [IDX_W:0] C_FULL_COUNT = (IDX_W+1)'(NUM_SLOTS);
  localparam logic [IDX_W:0] C_ONE        = (IDX_W+1)'(1);

  logic [NUM_SLOTS-1:0] free_map_q,      free_map_d;
  logic                 grant_valid_q,   grant_valid_d;
  logic [NUM_SLOTS-1:0] grant_onehot_q,  grant_onehot_d;
  logic [IDX_W-1:0]     grant_idx_q,     grant_idx_d;
  logic                 deny_q,          deny_d;
  logic                 exit_err_q,      exit_err_d;
  logic [IDX_W:0]       free_count_q,    free_count_d;
  logic [CNT_W-1:0]     entries_total_q, entries_total_d;

  logic [NUM_SLOTS-1:0] w_lowest_free;
  logic [IDX_W-1:0]     w_lowest_idx;
  logic                 w_any_free;
  logic [NUM_SLOTS-1:0] w_exit_mask;
  logic                 w_grant;
  logic                 w_exit_ok;

  // Lowest-index free slot, taken from the map as it stands this cycle
  // (before any same-cycle exit is applied).
  always_comb begin
    w_lowest_free = '0;
    w_lowest_idx  = '0;
    w_any_free    = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (free_map_q[i] && !w_any_free) begin
        w_any_free       = 1'b1;
        w_lowest_free[i] = 1'b1;
        w_lowest_idx     = IDX_W'(i);
      end
    end
  end

  // Decoding exit_idx against real slot positions only: an out-of-range
  // index yields an empty mask, which makes the range check implicit.
  always_comb begin
    w_exit_mask = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_exit_mask[i] = (psm.exit_idx == IDX_W'(i));
    end
  end

  assign w_grant   = psm.entry && w_any_free;
  assign w_exit_ok = psm.exit && (|w_exit_mask) && ((free_map_q & w_exit_mask) == '0);

  always_comb begin
    free_map_d = free_map_q;
    // A grant targets a free slot and a valid exit an occupied one, so the
    // two masks never overlap and can be applied in either order.
    if (w_grant) begin
      free_map_d = free_map_d & ~w_lowest_free;
    end
    if (w_exit_ok) begin
      free_map_d = free_map_d | w_exit_mask;
    end

    free_count_d = free_count_q;
    case ({w_grant, w_exit_ok})
      2'b10:   free_count_d = free_count_q - C_ONE;
      2'b01:   free_count_d = free_count_q + C_ONE;
      default: free_count_d = free_count_q;
    endcase

    entries_total_d = entries_total_q;
    if (w_grant) begin
      entries_total_d = entries_total_q + CNT_W'(1);
    end

    grant_valid_d  = w_grant;
    grant_onehot_d = w_grant ? w_lowest_free : '0;
    grant_idx_d    = w_grant ? w_lowest_idx : '0;
    deny_d         = psm.entry && !w_any_free;
    exit_err_d     = psm.exit && !w_exit_ok;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_map_q      <= '1;
      grant_valid_q   <= 1'b0;
      grant_onehot_q  <= '0;
      grant_idx_q     <= '0;
      deny_q          <= 1'b0;
      exit_err_q      <= 1'b0;
      free_count_q    <= C_FULL_COUNT;
      entries_total_q <= '0;
    end else begin
      free_map_q      <= free_map_d;
      grant_valid_q   <= grant_valid_d;
      grant_onehot_q  <= grant_onehot_d;
      grant_idx_q     <= grant_idx_d;
      deny_q          <= deny_d;
      exit_err_q      <= exit_err_d;
      free_count_q    <= free_count_d;
      entries_total_q <= entries_total_d;
    end
  end

  assign psm.free_map      = free_map_q;
  assign psm.grant_valid   = grant_valid_q;
  assign psm.grant_onehot  = grant_onehot_q;
  assign psm.grant_idx     = grant_idx_q;
  assign psm.deny          = deny_q;
  assign psm.exit_err      = exit_err_q;
  assign psm.free_count    = free_count_q;
  assign psm.full          = (free_count_q == '0);
  assign psm.empty         = (free_count_q == C_FULL_COUNT);
  assign psm.entries_total = entries_total_q;

endmodule
`default_nettype wire

// File: tb/tb_parking_slot_manager.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_slot_manager
// Description : Drives an 8-slot/16-bit allocator and a 6-slot/4-bit
//               allocator with the same request stream and checks both
//               against a slot-array reference model every cycle, plus
//               literal expectations for the directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_slot_manager;

  logic       clk;
  logic       reset;
  logic       s_entry;
  logic       s_exit;
  logic [2:0] s_idx;
  bit         run;

  int checks;
  int errors;

  parking_slot_manager_if #(.NUM_SLOTS(8), .IDX_W(3), .CNT_W(16)) b8 ();
  parking_slot_manager_if #(.NUM_SLOTS(6), .IDX_W(3), .CNT_W(4))  b6 ();

  assign b8.entry    = s_entry;
  assign b8.exit     = s_exit;
  assign b8.exit_idx = s_idx;
  assign b6.entry    = s_entry;
  assign b6.exit     = s_exit;
  assign b6.exit_idx = s_idx;

  parking_slot_manager #(.NUM_SLOTS(8), .IDX_W(3), .CNT_W(16)) dut8 (
    .clk(clk), .reset(reset), .psm(b8)
  );
  parking_slot_manager #(.NUM_SLOTS(6), .IDX_W(3), .CNT_W(4)) dut6 (
    .clk(clk), .reset(reset), .psm(b6)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: slot arrays, index 0 = 8 slots, 1 = 6 slots
  bit m_free [2][8];
  int m_ent  [2];
  bit m_gv   [2];
  int m_gi   [2];
  bit m_deny [2];
  bit m_err  [2];

  function automatic int nslots(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic int cmod(input int k);
    return (k == 0) ? 65536 : 16;
  endfunction

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int j = 0; j < 8; j++) m_free[k][j] = (j < nslots(k));
        m_ent[k] = 0; m_gv[k] = 0; m_gi[k] = 0; m_deny[k] = 0; m_err[k] = 0;
      end else begin
        int sel;
        int xi;
        bit xok;
        sel = -1;
        for (int j = nslots(k) - 1; j >= 0; j--) if (m_free[k][j]) sel = j;
        xi  = int'(s_idx);
        xok = s_exit && (xi < nslots(k)) && !m_free[k][xi];
        m_gv[k]   = s_entry && (sel >= 0);
        m_deny[k] = s_entry && (sel < 0);
        m_err[k]  = s_exit && !xok;
        m_gi[k]   = m_gv[k] ? sel : 0;
        if (m_gv[k]) begin
          m_free[k][sel] = 1'b0;
          m_ent[k] = (m_ent[k] + 1) % cmod(k);
        end
        if (xok) m_free[k][xi] = 1'b1;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      model_update();
    end
  end

  // ---------------- checking
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int k, input string p,
                           input logic [7:0] fm, input logic gv, input logic [7:0] oh,
                           input logic [2:0] gi, input logic dn, input logic er,
                           input logic [3:0] fc, input logic fl, input logic em,
                           input logic [15:0] et);
    logic [7:0] emap;
    int cnt;
    emap = '0;
    cnt  = 0;
    for (int j = 0; j < 8; j++) begin
      emap[j] = m_free[k][j];
      cnt += int'(m_free[k][j]);
    end
    chk({p, "free_map"},      64'(fm), 64'(emap));
    chk({p, "grant_valid"},   64'(gv), 64'(m_gv[k]));
    chk({p, "grant_onehot"},  64'(oh), m_gv[k] ? (64'd1 << m_gi[k]) : 64'd0);
    chk({p, "grant_idx"},     64'(gi), 64'(m_gi[k]));
    chk({p, "deny"},          64'(dn), 64'(m_deny[k]));
    chk({p, "exit_err"},      64'(er), 64'(m_err[k]));
    chk({p, "free_count"},    64'(fc), 64'(cnt));
    chk({p, "full"},          64'(fl), 64'(cnt == 0));
    chk({p, "empty"},         64'(em), 64'(cnt == nslots(k)));
    chk({p, "entries_total"}, 64'(et), 64'(m_ent[k]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (run) begin
        check_dut(0, "dut8.", b8.free_map, b8.grant_valid, b8.grant_onehot, b8.grant_idx,
                  b8.deny, b8.exit_err, b8.free_count, b8.full, b8.empty, b8.entries_total);
        check_dut(1, "dut6.", 8'(b6.free_map), b6.grant_valid, 8'(b6.grant_onehot), b6.grant_idx,
                  b6.deny, b6.exit_err, b6.free_count, b6.full, b6.empty, 16'(b6.entries_total));
      end
    end
  end

  // ---------------- stimulus
  // Drive one request just after a falling edge; return just after the
  // rising edge that samples it, when its registered result is visible.
  task automatic cycle(input bit e, input bit x, input int i);
    @(negedge clk);
    #1;
    s_entry = e;
    s_exit  = x;
    s_idx   = 3'(i);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset   = 1'b1;
    s_entry = 1'b0;
    s_exit  = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    clk = 1'b0; reset = 1'b1; s_entry = 1'b0; s_exit = 1'b0; s_idx = '0;
    run = 1'b0; checks = 0; errors = 0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    run   = 1'b1;

    chk("rst.free_map8",   64'(b8.free_map), 64'h0FF);
    chk("rst.free_map6",   64'(b6.free_map), 64'h03F);
    chk("rst.free_count8", 64'(b8.free_count), 64'd8);
    chk("rst.free_count6", 64'(b6.free_count), 64'd6);
    chk("rst.empty",       64'(b8.empty), 64'd1);
    chk("rst.full",        64'(b8.full), 64'd0);
    chk("rst.grant_valid", 64'(b8.grant_valid), 64'd0);
    chk("rst.entries",     64'(b8.entries_total), 64'd0);

    // Fill the lot: consecutive grants 0..7; the 6-slot lot denies the last two
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 0);
      chk("fill.grant_idx",    64'(b8.grant_idx), 64'(i));
      chk("fill.grant_onehot", 64'(b8.grant_onehot), 64'd1 << i);
      chk("fill.free_count",   64'(b8.free_count), 64'(7 - i));
      chk("fill.deny6",        64'(b6.deny), 64'(i >= 6));
    end
    chk("fill.full", 64'(b8.full), 64'd1);
    cycle(1, 0, 0);
    chk("full.deny",     64'(b8.deny), 64'd1);
    chk("full.free_map", 64'(b8.free_map), 64'd0);
    chk("full.grant",    64'(b8.grant_valid), 64'd0);

    cycle(0, 1, 5);
    chk("exit5.free_map",   64'(b8.free_map), 64'h20);
    chk("exit5.free_count", 64'(b8.free_count), 64'd1);
    cycle(1, 0, 0);
    chk("regrant5.grant_idx", 64'(b8.grant_idx), 64'd5);

    cycle(1, 1, 2);
    chk("simul.deny",     64'(b8.deny), 64'd1);
    chk("simul.free_map", 64'(b8.free_map), 64'h04);
    cycle(1, 0, 0);
    chk("regrant2.grant_idx", 64'(b8.grant_idx), 64'd2);

    cycle(0, 1, 3);
    chk("exit3.free_count", 64'(b8.free_count), 64'd1);
    cycle(0, 1, 3);
    chk("exit3again.exit_err",   64'(b8.exit_err), 64'd1);
    chk("exit3again.free_count", 64'(b8.free_count), 64'd1);
    cycle(0, 1, 7);
    chk("exit7.exit_err6",   64'(b6.exit_err), 64'd1);
    chk("exit7.free_count6", 64'(b6.free_count), 64'd1);
    chk("exit7.exit_err8",   64'(b8.exit_err), 64'd0);
    cycle(0, 0, 0);

    // Lifetime counter wrap: 16 grant/exit pairs from reset
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      cycle(1, 0, 0);
      chk("wrap.entries6", 64'(b6.entries_total), 64'(n % 16));
      chk("wrap.entries8", 64'(b8.entries_total), 64'(n));
      cycle(0, 1, 0);
    end

    // Half-cycle asynchronous reset with three slots in use
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    #1;
    reset = 1'b1;
    #1;
    chk("areset.free_map",    64'(b8.free_map), 64'h0FF);
    chk("areset.free_count",  64'(b8.free_count), 64'd8);
    chk("areset.grant_valid", 64'(b8.grant_valid), 64'd0);
    chk("areset.grant_idx",   64'(b8.grant_idx), 64'd0);
    #4;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("postreset.grant_idx",   64'(b8.grant_idx), 64'd0);
    chk("postreset.free_count",  64'(b8.free_count), 64'd7);
    chk("postreset.grant_valid", 64'(b8.grant_valid), 64'd1);

    // Randomised traffic, alternating entry-heavy and exit-heavy phases
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      #1;
      reset   = ($urandom_range(0, 59) == 0);
      s_entry = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      s_exit  = ($urandom_range(0, 1) == 1);
      s_idx   = 3'($urandom_range(0, 7));
    end
    @(negedge clk);
    #1;
    reset = 1'b0; s_entry = 1'b0; s_exit = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/parking_slot_manager.md
# parking_slot_manager

Registered, parametrised slot allocator for the smart parking controller. It keeps an occupancy map of `NUM_SLOTS` spaces and grants the lowest-index free slot to each arriving car. It frees slots on exit by index and maintains free-slot and lifetime-entry counters. It sits between the gate sensors and the display/barrier logic, and replaces the single-step combinational capacity update with a stateful block.

## Interface
- `NUM_SLOTS`, 8, number of parking spaces (2..64)
- `IDX_W`, 3, slot index width; must equal ceil(log2(`NUM_SLOTS`))
- `CNT_W`, 16, width of the lifetime entry counter
- `clk`  in  1  single system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears/initialises all state immediately
- `entry`  in  1  car-arrival request; sampled every rising edge, one request per high cycle
- `exit`  in  1  car-departure request; sampled every rising edge
- `exit_idx`  in  `IDX_W`  slot being vacated; qualified by `exit`
- `free_map`  out  `NUM_SLOTS`  registered occupancy map; bit i = 1 means slot i is free
- `grant_valid`  out  1  one-cycle pulse: entry granted
- `grant_onehot`  out  `NUM_SLOTS`  one-hot granted slot; all zero when `grant_valid`=0
- `grant_idx`  out  `IDX_W`  binary index of granted slot; 0 when `grant_valid`=0
- `deny`  out  1  one-cycle pulse: entry refused, lot full
- `exit_err`  out  1  one-cycle pulse: exit refused (index out of range or slot already free)
- `free_count`  out  `IDX_W`+1  number of free slots
- `full`  out  1  `free_count` == 0
- `empty`  out  1  `free_count` == `NUM_SLOTS`
- `entries_total`  out  `CNT_W`  count of granted entries, wraps modulo 2^`CNT_W`

## Operation
- Reset values:
  - `free_map` = all ones.
  - `free_count` = `NUM_SLOTS`.
  - `empty` = 1, `full` = 0.
  - `grant_valid`, `grant_onehot`, `grant_idx`, `deny`, `exit_err` = 0.
  - `entries_total` = 0.
- Entry: evaluated against the current `free_map`, before any same-cycle exit is applied.
  - If any bit is set, select the lowest set index i.
  - Next cycle: clear bit i, pulse `grant_valid`, drive `grant_onehot` = 1<<i and `grant_idx` = i, decrement `free_count`, increment `entries_total`.
  - If no bit is set, pulse `deny`. No other state changes.
- Exit: valid when `exit_idx` < `NUM_SLOTS` and `free_map[exit_idx]` == 0.
  - Valid: set the bit next cycle and increment `free_count`.
  - Invalid: pulse `exit_err`. No other state changes.
- Simultaneous entry and exit in the same cycle:
  - Both are processed independently.
  - The granted slot and the vacated slot are necessarily distinct, because a grant picks a free slot and a valid exit targets an occupied one.
  - Net `free_count` change is 0 when both succeed.
  - When the lot is full, the entry is denied even if the same-cycle exit is valid. The slot becomes available from the following cycle.
- `free_count` must always equal the popcount of `free_map`. It never underflows below 0 or exceeds `NUM_SLOTS`.
- `full` and `empty` are derived from the registered `free_count` and change in the same cycle as it does.
- `entries_total` wraps from 2^`CNT_W`-1 to 0 without any flag.
- Unused states: none. The block is a register file plus counters. There is no multi-cycle FSM; each request completes in one cycle.

## Timing
- All outputs are registered. A request sampled at edge N has its effect visible after edge N; there is no combinational path from input to output.
- Pulse outputs (`grant_valid`, `deny`, `exit_err`) are high for exactly one cycle per sampled request. `entry` held high for k cycles produces k independent requests.
- Back-to-back entries on consecutive cycles receive consecutive lowest-free slots, since each cycle sees the map as updated by the previous grant. Throughput is one entry plus one exit per cycle.
- Reset asserted mid-operation:
  - All state returns to reset values asynchronously.
  - Requests sampled while `reset` is high are discarded.
  - The first request accepted is the one sampled at the first rising edge after `reset` falls.

## Test plan
- Reset, then pulse `entry` 8 times on consecutive cycles (`NUM_SLOTS`=8) -> `grant_idx` sequence 0..7, `free_count` 8->0, `full`=1 after the 8th grant; a 9th `entry` -> `deny`=1, map unchanged.
- Fill the lot, `exit` with `exit_idx`=5 -> `free_map`=8'b0010_0000, `free_count`=1; next `entry` -> `grant_idx`=5.
- Lot full, same cycle `entry`=1 and `exit`=1 with `exit_idx`=2 -> `deny`=1 and slot 2 freed; next-cycle `entry` -> `grant_idx`=2.
- `exit` on a free slot 3, and (for `NUM_SLOTS`=6) `exit_idx`=7 -> `exit_err` pulse each time, `free_count` unchanged.
- Preload `entries_total` near wrap (`CNT_W`=4, 16 grant/exit pairs) -> counter reads 15 then 0.
- Assert `reset` for half a cycle mid-sequence with 3 slots used -> `free_map` all ones, `free_count`=8, pulses 0 immediately.
